// File: rtl/memory_ctrl.sv
// memory_ctrl: single-port synchronous word memory with a valid/ready request
// port, a fixed-latency response pipeline, out-of-range flagging and a clear
// engine that zeroes the whole array after reset or on command.
module memory_ctrl #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 12,
  parameter int COUNT        = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  // Array index width is sized to COUNT, not to the address bus, so the
  // array maps onto exactly COUNT words.
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [ADDR_WIDTH:0] COUNT_EXT = (ADDR_WIDTH + 1)'(COUNT);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(COUNT - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                  state_reg;
  logic [IDX_W-1:0]        ptr_reg;
  logic                    busy_reg;

  logic [DATA_WIDTH-1:0]   mem [0:COUNT-1];
  logic [DATA_WIDTH-1:0]   mem_rdata_reg;

  logic                    in_range;
  logic                    accept;
  logic                    clearing;
  logic [IDX_W-1:0]        mem_idx;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;

  logic [READ_LATENCY-1:0] valid_pipe_reg;
  logic [READ_LATENCY-1:0] err_pipe_reg;
  logic                    rd0_reg;
  logic [DATA_WIDTH-1:0]   stage0_data;

  // Unsigned compare at full address width plus one bit so that
  // COUNT == 2**ADDR_WIDTH never flags an error.
  assign in_range  = ({1'b0, req_addr} < COUNT_EXT);
  assign clearing  = (state_reg == ST_CLEAR);
  assign req_ready = (state_reg == ST_IDLE) && !clear_req;
  assign accept    = req_valid && req_ready;
  assign mem_idx   = req_addr[IDX_W-1:0];

  // The clear engine owns the write port while it runs; no request can be
  // accepted then, so the two writers never collide.
  assign mem_we    = clearing || (accept && req_write && in_range);
  assign mem_waddr = clearing ? ptr_reg : mem_idx;
  assign mem_wdata = clearing ? '0 : req_wdata;
  assign rd_en     = accept && !req_write && in_range;

  assign busy      = busy_reg;

  // Clear-engine sequencing: walk the pointer over every word, then idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (ptr_reg == LAST_IDX) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            ptr_reg <= ptr_reg + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_reg <= ST_CLEAR;
            busy_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_CLEAR;
          ptr_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  // Block RAM: one write port and a registered read that returns the
  // pre-write contents of the addressed word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_en) begin
      mem_rdata_reg <= mem[mem_idx];
    end
  end

  // Response control pipeline: valid and error flags shift one stage per
  // cycle; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe_reg <= '0;
      err_pipe_reg   <= '0;
      rd0_reg        <= 1'b0;
    end else begin
      valid_pipe_reg[0] <= accept;
      err_pipe_reg[0]   <= accept && !in_range;
      rd0_reg           <= rd_en;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        err_pipe_reg[i]   <= err_pipe_reg[i-1];
      end
    end
  end

  // Writes and out-of-range accesses carry zero data; the unreset RAM
  // output register is masked until a real read has loaded it.
  assign stage0_data = rd0_reg ? mem_rdata_reg : '0;

  assign rsp_valid = valid_pipe_reg[READ_LATENCY-1];
  assign rsp_err   = err_pipe_reg[READ_LATENCY-1];

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign rsp_rdata = stage0_data;
    end else begin : g_latn
      logic [DATA_WIDTH-1:0] data_pipe_reg [1:READ_LATENCY-1];

      // Extra data stages that stretch the read path to READ_LATENCY.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 1; i < READ_LATENCY; i++) begin
            data_pipe_reg[i] <= '0;
          end
        end else begin
          data_pipe_reg[1] <= stage0_data;
          for (int i = 2; i < READ_LATENCY; i++) begin
            data_pipe_reg[i] <= data_pipe_reg[i-1];
          end
        end
      end

      assign rsp_rdata = data_pipe_reg[READ_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl: two instances (latency 1 and 3) share
// one stimulus stream; a reference model pushes expected responses on each
// accepted request and per-instance monitors pop and compare.
module tb_memory_ctrl;

  localparam int DW  = 12;
  localparam int AW  = 12;
  localparam int CNT = 1337;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_req = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;

  logic          ready1, busy1, v1, e1;
  logic [DW-1:0] d1;
  logic          ready3, busy3, v3, e3;
  logic [DW-1:0] d3;

  always #5 clk = ~clk;

  memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT(CNT), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1), .busy(busy1)
  );

  memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT(CNT), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .req_valid(req_valid), .req_ready(ready3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3), .busy(busy3)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          q1[$];
  exp_t          q3[$];
  logic [DW-1:0] model [CNT];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            m_busy = 1'b1;
  int            m_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: clear engine, acceptance and expected responses
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b1;
      m_ptr  = 0;
      q1.delete();
      q3.delete();
    end else begin
      cyc++;
      if (m_busy) begin
        model[m_ptr] = '0;
        if (m_ptr == CNT - 1) begin
          m_busy = 1'b0;
          m_ptr  = 0;
        end else begin
          m_ptr++;
        end
      end else if (clear_req) begin
        m_busy = 1'b1;
      end else if (req_valid) begin
        exp_t e;
        e.acc = cyc;
        if (int'(req_addr) >= CNT) begin
          e.data = '0;
          e.err  = 1'b1;
        end else if (req_write) begin
          e.data = '0;
          e.err  = 1'b0;
          model[req_addr] = req_wdata;
        end else begin
          e.data = model[req_addr];
          e.err  = 1'b0;
        end
        q1.push_back(e);
        q3.push_back(e);
      end
    end
  end

  // Monitors: status every cycle, responses whenever rsp_valid is seen
  initial forever begin
    exp_t e;
    @(negedge clk);
    chk("ready1", ready1, !m_busy && !clear_req);
    chk("ready3", ready3, !m_busy && !clear_req);
    chk("busy1", busy1, m_busy);
    chk("busy3", busy3, m_busy);
    if (v1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp1 actual=valid required=no_response (t=%0t)", $time);
      end else begin
        e = q1.pop_front();
        chk("rdata1", d1, e.data);
        chk("err1", e1, e.err);
        chk("latency1", cyc - e.acc, 0);
      end
    end
    if (v3) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp3 actual=valid required=no_response (t=%0t)", $time);
      end else begin
        e = q3.pop_front();
        chk("rdata3", d3, e.data);
        chk("err3", e3, e.err);
        chk("latency3", cyc - e.acc, 2);
      end
    end
  end

  task automatic drive(input bit v, input bit w, input int a, input int d, input bit clr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_write = w;
    req_addr  = AW'(a);
    req_wdata = DW'(d);
    clear_req = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (n < 2 * CNT) begin
      @(negedge clk);
      if (!busy3) break;
      n++;
    end
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (n < 2 * CNT) begin
      @(negedge clk);
      if (ready3) break;
      n++;
    end
  endtask

  task automatic pulse_reset(input string tag);
    int n;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    clear_req = 1'b0;
    #1;
    chk({tag, "_rsp_valid1"}, v1, 0);
    chk({tag, "_rsp_valid3"}, v3, 0);
    chk({tag, "_rsp_rdata3"}, d3, 0);
    chk({tag, "_rsp_err3"}, e3, 0);
    chk({tag, "_busy"}, busy3, 1);
    chk({tag, "_ready"}, ready3, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_busy(n);
    chk({tag, "_busy_cycles"}, n, CNT);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    pulse_reset("reset");

    // Freshly cleared words read back as zero
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 668, 0, 0);
    drive(1, 0, CNT - 1, 0, 0);
    idle(5);

    // Full sweep: write addr+1 everywhere, then read back-to-back
    for (int a = 0; a < CNT; a++) drive(1, 1, a, a + 1, 0);
    for (int a = 0; a < CNT; a++) drive(1, 0, a, 0, 0);
    idle(5);

    // Out-of-range accesses leave the array untouched
    drive(1, 1, CNT, 'hABC, 0);
    drive(1, 0, CNT, 0, 0);
    drive(1, 0, 4095, 0, 0);
    drive(1, 0, CNT - 1, 0, 0);
    idle(5);

    // Read-after-write on consecutive edges
    drive(1, 1, 7, 'h5A5, 0);
    drive(1, 0, 7, 0, 0);
    idle(5);

    // clear_req collides with a request while two reads are in flight
    drive(1, 0, 100, 0, 0);
    drive(1, 0, 200, 0, 0);
    drive(1, 0, 300, 0, 1);
    fork
      count_not_ready(n);
      idle(1);
    join
    chk("clear_ready_low_cycles", n, CNT + 1);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 668, 0, 0);
    drive(1, 0, CNT - 1, 0, 0);
    drive(1, 0, 100, 0, 0);
    drive(1, 0, 7, 0, 0);
    idle(5);

    // Reset in the middle of a clear
    drive(0, 0, 0, 0, 1);
    idle(500);
    pulse_reset("rst_in_clear");

    // Reset with a read burst in flight
    drive(1, 1, 5, 'h123, 0);
    drive(1, 0, 5, 0, 0);
    drive(1, 0, 5, 0, 0);
    drive(1, 0, 5, 0, 0);
    pulse_reset("rst_in_burst");
    drive(1, 0, 5, 0, 0);
    idle(6);

    chk("pending_rsp1", q1.size(), 0);
    chk("pending_rsp3", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
